// File: rtl/crc.sv
// ============================================================================
// Module      : crc
// Description : Parallel CRC-10 generator (CRC-10/ATM polynomial). Folds one
//               DATA_W-bit word into a running CRC register on every clock
//               where en is high; dout is the register itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc #(
    parameter int              DATA_W = 32,
    parameter int              CRC_W  = 10,
    parameter logic [CRC_W-1:0] POLY  = 10'h233,
    parameter logic [CRC_W-1:0] INIT  = 10'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [CRC_W-1:0]  dout
);

    // Running CRC state; the only storage in the block.
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_crc_next;

    // Fold the whole word in one cycle by unrolling DATA_W serial LFSR steps,
    // most significant data bit first. Synthesis collapses this into an XOR
    // network; no reflection and no final XOR are applied.
    always_comb begin
        logic [CRC_W-1:0] v_crc;
        logic             v_fb;
        v_crc = r_crc;
        v_fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            v_fb  = v_crc[CRC_W-1] ^ din[i];
            v_crc = {v_crc[CRC_W-2:0], 1'b0} ^ (v_fb ? POLY : {CRC_W{1'b0}});
        end
        w_crc_next = v_crc;
    end

    // CRC register: asynchronous clear to INIT, update only on enabled edges
    // so din (even if undefined) is ignored while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= INIT;
        end else if (en) begin
            r_crc <= w_crc_next;
        end
    end

    assign dout = r_crc;

endmodule

`default_nettype wire

// File: tb/tb_crc.sv
// ============================================================================
// Module      : tb_crc
// Description : Self-checking bench for crc. Expected values come from
//               fixed vectors and from a polynomial long-division model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] din;
    logic [9:0]  dout;

    int tests;
    int fails;
    logic [9:0] model_crc;

    crc #(
        .DATA_W (32),
        .CRC_W  (10),
        .POLY   (10'h233),
        .INIT   (10'h000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ((crc << 32) ^ (din << 10)) mod (x^10+x^9+x^5+x^4+x+1)
    // computed as plain GF(2) long division on a 42-bit dividend.
    function automatic logic [9:0] ref_next(input logic [9:0] c, input logic [31:0] d);
        logic [41:0] m;
        logic [41:0] p;
        m = ({32'b0, c} << 32) ^ ({10'b0, d} << 10);
        p = 42'h633;
        for (int i = 41; i >= 10; i--) begin
            if (m[i]) m = m ^ (p << (i - 10));
        end
        return m[9:0];
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: dout=0x%03h expected 0x%03h", name, act, exp);
        end
    endtask

    // Assert reset across two edges, release just after an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        model_crc = 10'h000;
    endtask

    // Present one input set for one edge, then compare 1 time unit later.
    task automatic cycle(input logic e, input logic [31:0] d, input string name);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
        if (e) model_crc = ref_next(model_crc, d);
        check(name, dout, model_crc);
    endtask

    typedef struct {
        logic [31:0] din;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        tests = 0;
        fails = 0;
        model_crc = 10'h000;
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 32'h0;

        vecs[0] = '{din: 32'h0000_0001, exp: 10'h233};
        vecs[1] = '{din: 32'h0000_0002, exp: 10'h255};
        vecs[2] = '{din: 32'h0000_0003, exp: 10'h066};
        vecs[3] = '{din: 32'h0000_0000, exp: 10'h000};

        // Held reset with en toggling and random data.
        for (int i = 0; i < 3; i++) begin
            en  = i[0];
            din = $urandom;
            @(posedge clk);
            #1;
            check("reset_hold", dout, 10'h000);
        end
        #1;
        rst_n = 1'b1;

        // Single-word vectors from a fresh reset.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            en  = 1'b1;
            din = vecs[i].din;
            @(posedge clk);
            #1;
            check("single_word", dout, vecs[i].exp);
            en = 1'b0;
        end

        // Hold with en low while din churns.
        do_reset();
        cycle(1'b1, 32'h0000_0001, "hold_load");
        for (int i = 0; i < 10; i++) begin
            en  = 1'b0;
            din = $urandom;
            @(posedge clk);
            #1;
            check("hold", dout, 10'h233);
        end

        // Asynchronous reset mid-clock, without waiting for an edge.
        do_reset();
        cycle(1'b1, 32'h0000_0001, "async_load");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dout, 10'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_crc = 10'h000;

        // 100 back-to-back words, mid-stream reset after word 50.
        for (int i = 1; i <= 100; i++) begin
            cycle(1'b1, 32'(i), "stream");
            if (i == 50) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("midstream_reset", dout, 10'h000);
                @(negedge clk);
                en = 1'b0;
                @(posedge clk);
                #1;
                rst_n     = 1'b1;
                model_crc = 10'h000;
                cycle(1'b1, 32'h0000_0001, "restart");
                check("restart_value", dout, 10'h233);
            end
        end

        // Linearity from INIT=0: CRC(a^b) = CRC(a)^CRC(b).
        begin
            logic [31:0] a;
            logic [31:0] b;
            logic [9:0]  ca;
            logic [9:0]  cb;
            a = $urandom;
            b = $urandom;
            do_reset();
            cycle(1'b1, a, "lin_a");
            ca = dout;
            do_reset();
            cycle(1'b1, b, "lin_b");
            cb = dout;
            do_reset();
            en  = 1'b1;
            din = a ^ b;
            @(posedge clk);
            #1;
            check("linearity", dout, ca ^ cb);
            en = 1'b0;
        end

        // Random en and din against the division model.
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
